// File: rtl/matmul_mem_sequencer.sv
// Tile sequencer that arbitrates the A/B/C RAM ports between the host and the matmul engine.
// Optional cycle counter output enabled by defining CYCLE_COUNT_EN.
module matmul_mem_sequencer #(
  parameter int DWIDTH   = 16,
  parameter int MAT_SIZE = 8,
  parameter int AWIDTH   = 7,
  parameter int RD_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       host_wr_en,
  input  logic                       host_rd_en,
  input  logic [1:0]                 host_sel,
  input  logic [AWIDTH-1:0]          host_addr,
  input  logic [MAT_SIZE*DWIDTH-1:0] host_wdata,
  output logic [MAT_SIZE*DWIDTH-1:0] host_rdata,
  output logic                       host_rvalid,
  output logic                       host_err,
  input  logic                       start,
  input  logic [AWIDTH-1:0]          a_base,
  input  logic [AWIDTH-1:0]          b_base,
  input  logic [AWIDTH-1:0]          c_base,
  output logic                       busy,
  output logic                       done,
  output logic                       eng_start,
  input  logic                       eng_done,
  input  logic [AWIDTH-1:0]          eng_a_addr,
  input  logic [AWIDTH-1:0]          eng_b_addr,
  input  logic [MAT_SIZE*DWIDTH-1:0] eng_c_data,
  input  logic                       eng_c_valid,
  output logic [AWIDTH-1:0]          ram_a_addr,
  output logic [AWIDTH-1:0]          ram_b_addr,
  output logic [AWIDTH-1:0]          ram_c_addr,
  output logic                       ram_a_we,
  output logic                       ram_b_we,
  output logic                       ram_c_we,
  output logic [MAT_SIZE*DWIDTH-1:0] ram_ab_wdata,
  output logic [MAT_SIZE*DWIDTH-1:0] ram_c_wdata,
  input  logic [MAT_SIZE*DWIDTH-1:0] ram_c_rdata
`ifdef CYCLE_COUNT_EN
  ,
  output logic [31:0]                cycle_count
`endif
);

  localparam int RW = $clog2(MAT_SIZE + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, FLUSH, DONE} state_t;

  state_t            state, next_state;
  logic [AWIDTH-1:0] a_base_q, b_base_q, c_base_q;
  logic [RW-1:0]     row_cnt;
  logic [RD_LAT-1:0] rd_pipe;

  logic in_idle, start_ok;
  logic host_wr_a, host_wr_b, host_wr_c, host_rd_c;
  logic rows_full, c_accept, err_set;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    eng_start  = 1'b0;
    case (state)
      IDLE:   if (start) next_state = LAUNCH;
      LAUNCH: begin
        eng_start  = 1'b1;
        busy       = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (eng_done) next_state = FLUSH;
      end
      FLUSH: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Host owns the RAM ports only while idle; a simultaneous write beats a read.
  always_comb begin
    in_idle   = (state == IDLE);
    start_ok  = in_idle && start;
    host_wr_a = in_idle && host_wr_en && (host_sel == 2'd0);
    host_wr_b = in_idle && host_wr_en && (host_sel == 2'd1);
    host_wr_c = in_idle && host_wr_en && (host_sel == 2'd2);
    host_rd_c = in_idle && host_rd_en && !host_wr_en && (host_sel == 2'd2);
    rows_full = (row_cnt >= RW'(MAT_SIZE));
    c_accept  = (state == RUN) && eng_c_valid && !rows_full;
    err_set   = (busy && (host_wr_en || host_rd_en))
             || ((state == RUN) && eng_c_valid && rows_full)
             || ((state == FLUSH) && !rows_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_a_addr   <= '0;
      ram_b_addr   <= '0;
      ram_c_addr   <= '0;
      ram_a_we     <= 1'b0;
      ram_b_we     <= 1'b0;
      ram_c_we     <= 1'b0;
      ram_ab_wdata <= '0;
      ram_c_wdata  <= '0;
      a_base_q     <= '0;
      b_base_q     <= '0;
      c_base_q     <= '0;
      row_cnt      <= '0;
      host_err     <= 1'b0;
    end else begin
      ram_a_we <= host_wr_a;
      ram_b_we <= host_wr_b;
      ram_c_we <= host_wr_c || c_accept;
      if (host_wr_a) begin
        ram_a_addr   <= host_addr;
        ram_ab_wdata <= host_wdata;
      end
      if (host_wr_b) begin
        ram_b_addr   <= host_addr;
        ram_ab_wdata <= host_wdata;
      end
      if (host_wr_c) begin
        ram_c_addr  <= host_addr;
        ram_c_wdata <= host_wdata;
      end
      if (host_rd_c) ram_c_addr <= host_addr;
      if (state == RUN) begin
        ram_a_addr <= a_base_q + eng_a_addr;
        ram_b_addr <= b_base_q + eng_b_addr;
      end
      if (c_accept) begin
        ram_c_addr  <= c_base_q + AWIDTH'(row_cnt);
        ram_c_wdata <= eng_c_data;
        row_cnt     <= row_cnt + RW'(1);
      end
      if (start_ok) begin
        a_base_q <= a_base;
        b_base_q <= b_base;
        c_base_q <= c_base;
        row_cnt  <= '0;
      end
      host_err <= host_err || err_set;
    end
  end

  // Read pipeline runs independently of the FSM so reads issued before a start still complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe     <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      rd_pipe[0] <= host_rd_c;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      host_rvalid <= rd_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1]) host_rdata <= ram_c_rdata;
    end
  end

`ifdef CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                              cycle_count <= '0;
    else if (start_ok)                      cycle_count <= '0;
    else if (busy && (cycle_count != '1))   cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_matmul_mem_sequencer.sv
// Scoreboard bench for matmul_mem_sequencer: RAM writes and host reads are predicted and checked by a monitor.
module tb_matmul_mem_sequencer;
  localparam int DW = 16;
  localparam int MS = 8;
  localparam int AW = 7;
  localparam int RL = 2;
  localparam int W  = MS * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_wr_en, host_rd_en;
  logic [1:0]    host_sel;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_wdata, host_rdata;
  logic          host_rvalid, host_err;
  logic          start;
  logic [AW-1:0] a_base, b_base, c_base;
  logic          busy, done, eng_start, eng_done;
  logic [AW-1:0] eng_a_addr, eng_b_addr;
  logic [W-1:0]  eng_c_data;
  logic          eng_c_valid;
  logic [AW-1:0] ram_a_addr, ram_b_addr, ram_c_addr;
  logic          ram_a_we, ram_b_we, ram_c_we;
  logic [W-1:0]  ram_ab_wdata, ram_c_wdata, ram_c_rdata;
`ifdef CYCLE_COUNT_EN
  logic [31:0]   cycle_count;
`endif

  typedef struct {
    int            bank;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    int            due;
  } wr_t;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  matmul_mem_sequencer #(.DWIDTH(DW), .MAT_SIZE(MS), .AWIDTH(AW), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .host_wr_en(host_wr_en), .host_rd_en(host_rd_en), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_err(host_err),
    .start(start), .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy(busy), .done(done), .eng_start(eng_start), .eng_done(eng_done),
    .eng_a_addr(eng_a_addr), .eng_b_addr(eng_b_addr),
    .eng_c_data(eng_c_data), .eng_c_valid(eng_c_valid),
    .ram_a_addr(ram_a_addr), .ram_b_addr(ram_b_addr), .ram_c_addr(ram_c_addr),
    .ram_a_we(ram_a_we), .ram_b_we(ram_b_we), .ram_c_we(ram_c_we),
    .ram_ab_wdata(ram_ab_wdata), .ram_c_wdata(ram_c_wdata), .ram_c_rdata(ram_c_rdata)
`ifdef CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] c_pattern(input logic [AW-1:0] a);
    return {MS{16'hC000 | {9'h0, a}}};
  endfunction

  // C RAM model: read data follows the address the DUT presents.
  assign ram_c_rdata = c_pattern(ram_c_addr);

  // Monitor: every RAM write and host read-return must match the head of its scoreboard queue.
  int            m_bank;
  int            m_nwe;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;
  wr_t           m_w;
  rd_t           m_r;
  always @(negedge clk) begin
    m_nwe  = int'(ram_a_we) + int'(ram_b_we) + int'(ram_c_we);
    m_bank = ram_a_we ? 0 : (ram_b_we ? 1 : 2);
    m_addr = ram_a_we ? ram_a_addr : (ram_b_we ? ram_b_addr : ram_c_addr);
    m_data = ram_c_we ? ram_c_wdata : ram_ab_wdata;
    if (m_nwe != 0) begin
      n_checks++;
      if (m_nwe > 1 || wq.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL ram_write_unexpected: got %0d enables at cycle %0d, required none", m_nwe, cyc);
      end else begin
        m_w = wq.pop_front();
        if (m_w.bank !== m_bank || m_w.addr !== m_addr || m_w.data !== m_data || m_w.due != cyc) begin
          n_fail++;
          $display("[TB] FAIL ram_write: got bank %0d addr %0h cycle %0d data %0h, required bank %0d addr %0h cycle %0d data %0h",
                   m_bank, m_addr, cyc, m_data, m_w.bank, m_w.addr, m_w.due, m_w.data);
        end
      end
    end
    if (host_rvalid) begin
      n_checks++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL host_rvalid_unexpected: got rvalid at cycle %0d, required none", cyc);
      end else begin
        m_r = rq.pop_front();
        if (m_r.data !== host_rdata || m_r.due != cyc) begin
          n_fail++;
          $display("[TB] FAIL host_read: got cycle %0d data %0h, required cycle %0d data %0h",
                   cyc, host_rdata, m_r.due, m_r.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic launch(input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [AW-1:0] cb);
    a_base = ab; b_base = bb; c_base = cb; start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  // Drives n C beats in RUN; only the first MS are predicted as RAM writes.
  task automatic drive_rows(input int n, input logic [AW-1:0] cb);
    for (int r = 0; r < n; r++) begin
      eng_c_valid = 1'b1;
      eng_c_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (r < MS) wq.push_back('{2, AW'(cb + r), eng_c_data, cyc + 1});
      step();
    end
    eng_c_valid = 1'b0;
  endtask

  task automatic wait_done(output int pulses, output logic busy_after);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    busy_after = busy;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if ({busy, done, eng_start, host_rvalid, host_err} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_status: got %b required 00000", {busy, done, eng_start, host_rvalid, host_err});
    end
    n_checks++;
    if ({ram_a_we, ram_b_we, ram_c_we} !== 3'b0 || ram_c_addr !== '0 || ram_c_wdata !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_ram: got we %b addr %0h required 000 / 0", {ram_a_we, ram_b_we, ram_c_we}, ram_c_addr);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_host_io();
    logic [W-1:0] d;
    host_wr_en = 1'b1; host_sel = 2'd0; host_addr = 7'd3;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    host_wdata = d; wq.push_back('{0, 7'd3, d, cyc + 1});
    step();
    host_sel = 2'd1; host_addr = 7'd5;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    host_wdata = d; wq.push_back('{1, 7'd5, d, cyc + 1});
    step();
    host_rd_en = 1'b1; host_sel = 2'd2; host_addr = 7'd9;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    host_wdata = d; wq.push_back('{2, 7'd9, d, cyc + 1});
    step();
    host_rd_en = 1'b0; host_sel = 2'd3; host_addr = 7'd11;
    step();
    host_wr_en = 1'b0; host_rd_en = 1'b1; host_sel = 2'd2; host_addr = 7'd10;
    rq.push_back('{c_pattern(7'd10), cyc + RL + 1});
    step();
    host_rd_en = 1'b0;
    step();
    @(negedge clk);
    n_checks++;
    if (host_rvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_early: got rvalid %b required 0", host_rvalid);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== c_pattern(7'd10)) begin
      n_fail++;
      $display("[TB] FAIL read_c10: got rvalid %b data %0h required 1 / %0h", host_rvalid, host_rdata, c_pattern(7'd10));
    end
    repeat (3) step();
  endtask

  task automatic test_tile_op();
    int   pulses;
    logic busy_after;
    a_base = 7'h10; b_base = 7'h20; c_base = 7'h7C; start = 1'b1;
    step();
    start = 1'b0; c_base = 7'h00; a_base = 7'h00; b_base = 7'h00;
    @(negedge clk);
    n_checks++;
    if (eng_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL launch: got eng_start %b busy %b required 1 1", eng_start, busy);
    end
    step();
    eng_a_addr = 7'd5; eng_b_addr = 7'h70;
    for (int r = 0; r < MS; r++) begin
      eng_c_valid = 1'b1;
      eng_c_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      eng_done    = (r == MS - 1);
      wq.push_back('{2, AW'(7'h7C + r), eng_c_data, cyc + 1});
      if (r == 0) begin
        @(negedge clk);
        n_checks++;
        if (eng_start !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL eng_start_pulse: got %b required 0", eng_start);
        end
      end
      if (r == 1) begin
        @(negedge clk);
        n_checks++;
        if (ram_a_addr !== 7'h15 || ram_b_addr !== 7'h10) begin
          n_fail++;
          $display("[TB] FAIL eng_addr_map: got a %0h b %0h required 15 10", ram_a_addr, ram_b_addr);
        end
      end
      step();
    end
    eng_c_valid = 1'b0; eng_done = 1'b0;
    wait_done(pulses, busy_after);
    n_checks++;
    if (pulses != 1 || busy_after !== 1'b0 || host_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL tile_done: got pulses %0d busy %b err %b required 1 0 0", pulses, busy_after, host_err);
    end
  endtask

  task automatic test_overflow();
    int   pulses;
    logic busy_after;
    launch(7'h00, 7'h00, 7'h40);
    for (int r = 0; r <= MS; r++) begin
      eng_c_valid = 1'b1;
      eng_c_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (r < MS) wq.push_back('{2, AW'(7'h40 + r), eng_c_data, cyc + 1});
      else begin
        @(negedge clk);
        n_checks++;
        if (host_err !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL overflow_pre: got err %b required 0", host_err);
        end
      end
      step();
    end
    eng_c_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (host_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overflow_err: got err %b required 1", host_err);
    end
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    wait_done(pulses, busy_after);
    n_checks++;
    if (pulses != 1 || busy_after !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL overflow_done: got pulses %0d busy %b required 1 0", pulses, busy_after);
    end
  endtask

  task automatic test_short();
    do_reset();
    launch(7'h00, 7'h00, 7'h00);
    drive_rows(6, 7'h00);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (host_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL short_flush: got err %b busy %b required 0 1", host_err, busy);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (host_err !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL short_err: got err %b done %b required 1 1", host_err, done);
    end
    step();
  endtask

  task automatic test_busy_access();
    int   pulses;
    logic busy_after;
    do_reset();
    launch(7'h00, 7'h00, 7'h20);
    host_wr_en = 1'b1; host_sel = 2'd0; host_addr = 7'd1; start = 1'b1;
    step();
    host_wr_en = 1'b0; host_rd_en = 1'b1; host_sel = 2'd2; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (host_err !== 1'b1 || eng_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL busy_access: got err %b eng_start %b busy %b required 1 0 1", host_err, eng_start, busy);
    end
    step();
    host_rd_en = 1'b0;
    drive_rows(MS, 7'h20);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    wait_done(pulses, busy_after);
    n_checks++;
    if (pulses != 1 || busy_after !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL busy_done: got pulses %0d busy %b required 1 0", pulses, busy_after);
    end
  endtask

  task automatic test_reset_mid_run();
    int   pulses;
    logic busy_after;
    do_reset();
    launch(7'h00, 7'h00, 7'h50);
    drive_rows(2, 7'h50);
    eng_c_valid = 1'b1; reset = 1'b1;
    step();
    eng_c_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || {ram_a_we, ram_b_we, ram_c_we} !== 3'b0 || eng_start !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_run: got busy %b we %b required 0 000", busy, {ram_a_we, ram_b_we, ram_c_we});
    end
    step();
    launch(7'h00, 7'h00, 7'h30);
    drive_rows(MS, 7'h30);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    wait_done(pulses, busy_after);
    n_checks++;
    if (pulses != 1 || busy_after !== 1'b0 || host_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL restart_done: got pulses %0d busy %b err %b required 1 0 0", pulses, busy_after, host_err);
    end
  endtask

  task automatic test_drain();
    repeat (10) step();
    n_checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d writes %0d reads pending required 0 0", wq.size(), rq.size());
    end
  endtask

  initial begin
    reset = 1'b1; host_wr_en = 1'b0; host_rd_en = 1'b0; host_sel = 2'd3;
    host_addr = '0; host_wdata = '0; start = 1'b0;
    a_base = '0; b_base = '0; c_base = '0;
    eng_done = 1'b0; eng_a_addr = '0; eng_b_addr = '0; eng_c_data = '0; eng_c_valid = 1'b0;
    test_reset();
    test_host_io();
    test_tile_op();
    test_overflow();
    test_short();
    test_busy_access();
    test_reset_mid_run();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
